rv32_alu_dec: RTL and testbench

Registered decode/issue stage that sits directly in front of the RV32I ALU. It accepts a fetched instruction with its register-file operands and produces a registered ALU bundle: ALU opcode, operand A/B, destination, write-enable, branch flag and branch target. A valid/ready handshake on each side gives one cycle of latency and full throughput. Flush and illegal-instruction detection are included.

---
 rtl/rv32_alu_dec_pkg.sv | 58 +++++
 rtl/rv32_alu_dec_if.sv | 33 +++
 rtl/rv32_imm_gen.sv | 11 +
 rtl/rv32_alu_dec.sv | 134 +++++++++++++
 tb/tb_rv32_alu_dec.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_alu_dec_pkg.sv
// Shared RV32I types: ALU opcodes (also consumed by the ALU), register index,
// major opcodes and the registered decode bundle.
package rv32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NEQ  = 4'd11,
    ALU_SBT  = 4'd12,
    ALU_SBTU = 4'd13
  } rv32_alu_op_t;

  typedef logic [4:0] rv32_register_t;

  localparam logic [6:0] RV32_OP     = 7'b0110011;
  localparam logic [6:0] RV32_OP_IMM = 7'b0010011;
  localparam logic [6:0] RV32_BRANCH = 7'b1100011;
  localparam logic [6:0] RV32_LUI    = 7'b0110111;
  localparam logic [6:0] RV32_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    rv32_alu_op_t   alu_opcode;
    logic [31:0]    op_a;
    logic [31:0]    op_b;
    rv32_register_t rd;
    logic           we;
    logic           is_branch;
    logic [31:0]    br_target;
    logic           illegal;
  } rv32_alu_bundle_t;

  // funct3 -> ALU op for OP/OP-IMM when funct7 selects the base encoding
  function automatic rv32_alu_op_t f3_alu_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_dec_if.sv
// Upstream/downstream handshake and payload of the decode/issue stage.
interface rv32_alu_dec_if
  import rv32_pkg::*;
#(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  rv32_alu_op_t    alu_opcode;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  rv32_register_t  rd;
  logic            we;
  logic            is_branch;
  logic [XLEN-1:0] br_target;
  logic            illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_opcode, op_a, op_b, rd, we,
           is_branch, br_target, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_opcode, op_a, op_b, rd, we,
           is_branch, br_target, illegal
  );
endinterface

// File: rtl/rv32_imm_gen.sv
// Sign-extended I/B/U immediates; only instruction bits above the opcode matter.
module rv32_imm_gen (
  input  logic [31:7] instr_i,
  output logic [31:0] imm_i_o,
  output logic [31:0] imm_b_o,
  output logic [31:0] imm_u_o
);
  assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_b_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u_o = {instr_i[31:12], 12'b0};
endmodule

// File: rtl/rv32_alu_dec.sv
// Registered RV32I decode/issue stage in front of the ALU: one cycle latency,
// full throughput, flush and illegal-instruction detection.
module rv32_alu_dec
  import rv32_pkg::*;
#(parameter int XLEN = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  rv32_alu_dec_if.slave     bus
);
  logic [XLEN-1:0]  imm_i, imm_b, imm_u;
  logic [6:0]       opcode, f7;
  logic [2:0]       f3;
  logic             ill;
  logic             cap;
  logic             valid_d, valid_q;
  rv32_alu_bundle_t dec_d, bundle_q;

  rv32_imm_gen u_imm (
    .instr_i (bus.instr[31:7]),
    .imm_i_o (imm_i),
    .imm_b_o (imm_b),
    .imm_u_o (imm_u)
  );

  assign opcode = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];

  always_comb begin
    dec_d           = '0;
    ill             = 1'b1;
    dec_d.rd        = bus.instr[11:7];
    dec_d.br_target = bus.pc + imm_b;
    case (opcode)
      RV32_OP: begin
        dec_d.op_a = bus.rs1_data;
        dec_d.op_b = bus.rs2_data;
        if (f7 == F7_BASE) begin
          dec_d.alu_opcode = f3_alu_op(f3);
          ill = 1'b0;
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec_d.alu_opcode = ALU_SUB;
          ill = 1'b0;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          dec_d.alu_opcode = ALU_SRA;
          ill = 1'b0;
        end
      end
      RV32_OP_IMM: begin
        dec_d.op_a = bus.rs1_data;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // shifts carry shamt in the immediate; funct7 picks SRL/SRA
          dec_d.op_b = {27'b0, bus.instr[24:20]};
          if (f7 == F7_BASE) begin
            dec_d.alu_opcode = f3_alu_op(f3);
            ill = 1'b0;
          end else if (f7 == F7_ALT && f3 == 3'b101) begin
            dec_d.alu_opcode = ALU_SRA;
            ill = 1'b0;
          end
        end else begin
          dec_d.op_b       = imm_i;
          dec_d.alu_opcode = f3_alu_op(f3);
          ill = 1'b0;
        end
      end
      RV32_BRANCH: begin
        dec_d.op_a      = bus.rs1_data;
        dec_d.op_b      = bus.rs2_data;
        dec_d.is_branch = 1'b1;
        ill = 1'b0;
        case (f3)
          3'b000:  dec_d.alu_opcode = ALU_EQ;
          3'b001:  dec_d.alu_opcode = ALU_NEQ;
          3'b100:  dec_d.alu_opcode = ALU_SLT;
          3'b101:  dec_d.alu_opcode = ALU_SBT;
          3'b110:  dec_d.alu_opcode = ALU_SLTU;
          3'b111:  dec_d.alu_opcode = ALU_SBTU;
          default: ill = 1'b1;
        endcase
      end
      RV32_LUI: begin
        dec_d.op_b = imm_u;
        ill = 1'b0;
      end
      RV32_AUIPC: begin
        dec_d.op_a = bus.pc;
        dec_d.op_b = imm_u;
        ill = 1'b0;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec_d.alu_opcode = ALU_ADD;
      dec_d.op_a       = '0;
      dec_d.op_b       = '0;
      dec_d.is_branch  = 1'b0;
    end
    dec_d.illegal = ill;
    dec_d.we      = !ill && !dec_d.is_branch && (dec_d.rd != '0);
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign cap          = bus.in_valid && bus.in_ready && !flush;

  // flush wins over both a capture and a pending hold
  always_comb begin
    valid_d = valid_q;
    if (flush)              valid_d = 1'b0;
    else if (cap)           valid_d = 1'b1;
    else if (bus.out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (cap) bundle_q <= dec_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.alu_opcode = bundle_q.alu_opcode;
  assign bus.op_a       = bundle_q.op_a;
  assign bus.op_b       = bundle_q.op_b;
  assign bus.rd         = bundle_q.rd;
  assign bus.we         = bundle_q.we;
  assign bus.is_branch  = bundle_q.is_branch;
  assign bus.br_target  = bundle_q.br_target;
  assign bus.illegal    = bundle_q.illegal;
endmodule

// File: tb/tb_rv32_alu_dec.sv
// Bench for rv32_alu_dec: mnemonic-level reference model checked every cycle,
// plus hand-computed literal expectations from the directed vectors.
module tb_rv32_alu_dec;
  import rv32_pkg::*;

  logic clk, rst, flush;
  int   total = 0;
  int   bad   = 0;

  rv32_alu_dec_if #(.XLEN(32)) bus ();

  rv32_alu_dec #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic rv32_alu_bundle_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                               input logic [31:0] a, input logic [31:0] b);
    rv32_alu_op_t rop [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    rv32_alu_op_t bop [8] = '{ALU_EQ, ALU_NEQ, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SBT, ALU_SLTU, ALU_SBTU};
    rv32_alu_bundle_t r;
    int   immi, immb;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok, shift;
    f3   = ins[14:12];
    f7   = ins[31:25];
    immi = $signed(ins[31:20]);
    immb = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    r = '0;
    ok = 1'b0;
    r.rd = ins[11:7];
    r.br_target = pc + immb;
    case (ins[6:0])
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        r.alu_opcode = (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : rop[f3];
        r.op_a = a; r.op_b = b;
      end
      7'h13: begin
        shift = (f3 == 3'd1 || f3 == 3'd5);
        ok = !shift || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
        r.alu_opcode = (shift && f7 == 7'h20) ? ALU_SRA : rop[f3];
        r.op_a = a;
        r.op_b = shift ? {27'b0, ins[24:20]} : immi;
      end
      7'h63: begin
        ok = (f3 != 3'd2 && f3 != 3'd3);
        r.alu_opcode = bop[f3];
        r.op_a = a; r.op_b = b; r.is_branch = 1'b1;
      end
      7'h37: begin ok = 1'b1; r.op_b = ins & 32'hFFFFF000; end
      7'h17: begin ok = 1'b1; r.op_a = pc; r.op_b = ins & 32'hFFFFF000; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r.alu_opcode = ALU_ADD; r.op_a = 0; r.op_b = 0; r.is_branch = 1'b0;
    end
    r.illegal = !ok;
    r.we = ok && !r.is_branch && (r.rd != 5'd0);
    return r;
  endfunction

  // Model of the stage's visible state, advanced on each clock / reset edge.
  logic             m_valid;
  rv32_alu_bundle_t m_b;
  initial begin
    m_valid = 1'b0;
    m_b     = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_valid = 1'b0;
      end else if (flush) begin
        m_valid = 1'b0;
      end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        m_valid = 1'b1;
        m_b = ref_dec(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("m.out_valid", bus.out_valid, m_valid);
        chk("m.in_ready", bus.in_ready, !m_valid || bus.out_ready);
        if (m_valid) begin
          chk("m.alu_opcode", bus.alu_opcode, m_b.alu_opcode);
          chk("m.op_a", bus.op_a, m_b.op_a);
          chk("m.op_b", bus.op_b, m_b.op_b);
          chk("m.rd", bus.rd, m_b.rd);
          chk("m.we", bus.we, m_b.we);
          chk("m.is_branch", bus.is_branch, m_b.is_branch);
          chk("m.br_target", bus.br_target, m_b.br_target);
          chk("m.illegal", bus.illegal, m_b.illegal);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.pc       = pc;
    bus.rs1_data = a;
    bus.rs2_data = b;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd7, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd4, f3, 5'd9, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  logic [31:0] vec[$];

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.instr = '0; bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    repeat (3) step();
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.alu_opcode", bus.alu_opcode, ALU_ADD);
    chk("rst.op_a", bus.op_a, 0);
    chk("rst.op_b", bus.op_b, 0);
    chk("rst.rd", bus.rd, 0);
    chk("rst.we", bus.we, 0);
    chk("rst.is_branch", bus.is_branch, 0);
    chk("rst.br_target", bus.br_target, 0);
    chk("rst.illegal", bus.illegal, 0);
    chk("rst.in_ready", bus.in_ready, 1);
    rst = 1'b0;
    step();

    // directed vectors, back to back
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    step();
    chk("add.valid", bus.out_valid, 1);
    chk("add.op", bus.alu_opcode, ALU_ADD);
    chk("add.op_a", bus.op_a, 5);
    chk("add.op_b", bus.op_b, 7);
    chk("add.rd", bus.rd, 3);
    chk("add.we", bus.we, 1);
    drive(32'h40435293, 32'h4, 32'h80000000, 32'd0);
    step();
    chk("srai.op", bus.alu_opcode, ALU_SRA);
    chk("srai.op_b", bus.op_b, 4);
    chk("srai.rd", bus.rd, 5);
    chk("srai.we", bus.we, 1);
    chk("srai.illegal", bus.illegal, 0);
    drive(32'hFE20DCE3, 32'h100, 32'd1, 32'd2);
    step();
    chk("bge.op", bus.alu_opcode, ALU_SBT);
    chk("bge.is_branch", bus.is_branch, 1);
    chk("bge.we", bus.we, 0);
    chk("bge.target", bus.br_target, 32'hF8);
    drive(32'hFE20DCE3, 32'h0, 32'd1, 32'd2);
    step();
    chk("bge0.target", bus.br_target, 32'hFFFFFFF8);
    drive(32'h123452B7, 32'h40, 32'hDEAD, 32'hBEEF);
    step();
    chk("lui.op_a", bus.op_a, 0);
    chk("lui.op_b", bus.op_b, 32'h12345000);
    chk("lui.op", bus.alu_opcode, ALU_ADD);
    chk("lui.we", bus.we, 1);
    drive(32'h12345037, 32'h44, 32'd0, 32'd0);
    step();
    chk("lui0.we", bus.we, 0);
    drive(32'h00000000, 32'h48, 32'd3, 32'd4);
    step();
    chk("zero.illegal", bus.illegal, 1);
    chk("zero.we", bus.we, 0);

    // broader decode coverage, checked by the model
    for (int f = 0; f < 8; f++) vec.push_back(enc_r(7'h00, 3'(f), 7'b0110011));
    for (int f = 0; f < 8; f++) vec.push_back(enc_r(7'h20, 3'(f), 7'b0110011));
    vec.push_back(enc_r(7'h01, 3'd0, 7'b0110011));
    for (int f = 0; f < 8; f++) vec.push_back(enc_i(12'hFFF, 3'(f)));
    vec.push_back(enc_i(12'h41F, 3'd5));
    vec.push_back(enc_i(12'h41F, 3'd1));
    vec.push_back(enc_i(12'h03F, 3'd5));
    vec.push_back(enc_i(12'h01F, 3'd1));
    for (int f = 0; f < 8; f++) vec.push_back(enc_b(13'h0FFE, 3'(f)));
    vec.push_back(enc_b(13'h1000, 3'd0));
    vec.push_back(32'hABCDE297);
    vec.push_back(32'h0000006F);
    vec.push_back(32'h00000073);
    foreach (vec[i]) begin
      drive(vec[i], $urandom, $urandom, $urandom);
      step();
    end

    // backpressure: hold three cycles, then release
    drive(32'h002081B3, 32'h10, 32'h11, 32'h1);
    step();
    bus.out_ready = 1'b0;
    drive(32'h002081B3, 32'h14, 32'h22, 32'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.valid", bus.out_valid, 1);
      chk("stall.op_a", bus.op_a, 32'h11);
      chk("stall.in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release.in_ready", bus.in_ready, 1);
    step();
    chk("release.op_a", bus.op_a, 32'h22);

    // flush during a stall, then flush against a capture
    bus.out_ready = 1'b0;
    drive(32'h002081B3, 32'h18, 32'h33, 32'h3);
    step();
    flush = 1'b1;
    step();
    chk("flush.valid", bus.out_valid, 0);
    flush = 1'b0;
    step();
    chk("after_flush.op_a", bus.op_a, 32'h33);
    bus.out_ready = 1'b1;
    drive(32'h002081B3, 32'h1C, 32'h44, 32'h4);
    flush = 1'b1;
    step();
    chk("flush_cap.valid", bus.out_valid, 0);
    flush = 1'b0;

    // asynchronous reset in the middle of a stall
    step();
    bus.out_ready = 1'b0;
    step();
    chk("pre_rst.valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1 chk("async_rst.valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
